// File: rtl/regfile_mp_sb.sv
// Multi-port register file with per-register busy scoreboard for RAW hazard detection.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec,
  output logic                wr_conflict
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;
  logic [NREGS-1:0] wb_hit;
  logic             conflict_nxt;

  // Later write ports are applied last, so the highest index wins on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int unsigned w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != '0))
          regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    conflict_nxt = 1'b0;
    for (int unsigned a = 0; a < NWR; a++) begin
      for (int unsigned b = a + 1; b < NWR; b++) begin
        if (wr_en[a] && wr_en[b] && (wr_addr[a*AW +: AW] == wr_addr[b*AW +: AW]) &&
            (wr_addr[a*AW +: AW] != '0))
          conflict_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    wb_hit = '0;
    for (int unsigned w = 0; w < NWR; w++) begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(i))) wb_hit[i] = 1'b1;
      end
    end
  end

  // Issue marking takes priority over writeback: the new producer supersedes the old one.
  always_comb begin
    busy_nxt = busy_q;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        if (iss_en && (iss_addr == AW'(i))) busy_nxt[i] = 1'b1;
        else if (wb_hit[i])                 busy_nxt[i] = 1'b0;
      end
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      wr_conflict <= 1'b0;
    end else begin
      busy_q      <= busy_nxt;
      wr_conflict <= conflict_nxt;
    end
  end

  assign busy_vec = busy_q;

  always_comb begin
    logic [AW-1:0] ra;
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      ra = rd_addr[p*AW +: AW];
      rd_data[p*XLEN +: XLEN] = regs[ra];
      rd_busy[p]              = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
      for (int unsigned w = 0; w < NWR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] != '0) && (wr_addr[w*AW +: AW] == ra)) begin
          rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
          rd_busy[p]              = 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: stimulus queues expected values, a negedge monitor checks them.
module tb_regfile_mp_sb;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                flush;
  logic [NREGS-1:0]    busy_vec;
  logic                wr_conflict;

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .flush(flush), .busy_vec(busy_vec), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  // kind: 0 rd_data[port], 1 rd_busy[port], 2 busy_vec, 3 wr_conflict
  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [63:0] exp;
  } chk_t;

  chk_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input string n, input int k, input int p, input logic [63:0] e);
    chk_t c;
    c.name = n; c.kind = k; c.port = p; c.exp = e;
    q.push_back(c);
  endtask

  task automatic exp_rd(input string n, input int p, input logic [31:0] d, input logic b);
    push({n, "_data"}, 0, p, {32'd0, d});
    push({n, "_busy"}, 1, p, {63'd0, b});
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int w, input int a, input logic [31:0] d);
    wr_en[w] = 1'b1;
    wr_addr[w*AW +: AW] = AW'(a);
    wr_data[w*XLEN +: XLEN] = d;
  endtask

  task automatic iss(input int a);
    iss_en = 1'b1;
    iss_addr = AW'(a);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [63:0] act;
      c = q.pop_front();
      case (c.kind)
        0:       act = {32'd0, rd_data[c.port*XLEN +: XLEN]};
        1:       act = {63'd0, rd_busy[c.port]};
        2:       act = {32'd0, busy_vec};
        default: act = {63'd0, wr_conflict};
      endcase
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL %s port=%0d got=0x%0h want=0x%0h", c.name, c.port, act, c.exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    rd_addr = '0;
    idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Post-reset sweep of every address on both ports.
    for (int a = 0; a < NREGS; a++) begin
      set_rd(0, a); set_rd(1, NREGS - 1 - a);
      exp_rd("rst_p0", 0, 32'h0, 1'b0);
      exp_rd("rst_p1", 1, 32'h0, 1'b0);
      if (a == 0) begin
        push("rst_busy_vec", 2, 0, 64'h0);
        push("rst_conflict", 3, 0, 64'h0);
      end
      cyc();
    end

    // Write x5; same-cycle read depends on bypass.
    set_wr(0, 5, 32'hDEADBEEF); set_rd(0, 5);
`ifdef REGFILE_BYPASS_EN
    exp_rd("x5_same", 0, 32'hDEADBEEF, 1'b0);
`else
    exp_rd("x5_same", 0, 32'h0, 1'b0);
`endif
    cyc();
    set_rd(0, 5); set_rd(1, 0); set_wr(0, 0, 32'h1234);
    exp_rd("x5_next", 0, 32'hDEADBEEF, 1'b0);
    exp_rd("x0_wr_same", 1, 32'h0, 1'b0);
    cyc();
    exp_rd("x0_after_wr", 1, 32'h0, 1'b0);
    push("x0_busy_vec", 2, 0, 64'h0);
    cyc();

    // Dual write to x7: port1 wins, conflict pulses one cycle.
    set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22);
    push("conf_before", 3, 0, 64'h0);
    cyc();
    set_rd(0, 7);
    exp_rd("x7_winner", 0, 32'h22, 1'b0);
    push("conf_pulse", 3, 0, 64'h1);
    cyc();
    push("conf_clear", 3, 0, 64'h0);
    set_wr(0, 8, 32'h33); set_wr(1, 6, 32'h44);
    cyc();
    set_rd(0, 8); set_rd(1, 6);
    exp_rd("x8", 0, 32'h33, 1'b0);
    exp_rd("x6", 1, 32'h44, 1'b0);
    push("conf_diff_addr", 3, 0, 64'h0);
    cyc();

    // Issue x3, then writeback+issue together, then writeback alone.
    iss(3);
    push("iss3_pre", 2, 0, 64'h0);
    cyc();
    set_rd(0, 3);
    push("iss3_vec", 2, 0, 64'h8);
    exp_rd("iss3_rd", 0, 32'h0, 1'b1);
    cyc();
    set_wr(0, 3, 32'h333); iss(3); set_rd(0, 5); set_rd(1, 5);
    exp_rd("x5_unrel", 1, 32'hDEADBEEF, 1'b0);
    cyc();
    set_rd(0, 3);
    push("iss_wins_vec", 2, 0, 64'h8);
    exp_rd("iss_wins_rd", 0, 32'h333, 1'b1);
    cyc();
    set_wr(1, 3, 32'h444);
    cyc();
    set_rd(0, 3);
    push("wb_clear_vec", 2, 0, 64'h0);
    exp_rd("wb_clear_rd", 0, 32'h444, 1'b0);
    cyc();

    // Flush overrides a simultaneous issue; issue on x0 is ignored.
    iss(1); cyc();
    iss(2); cyc();
    iss(9); cyc();
    push("pre_flush_vec", 2, 0, 64'h206);
    flush = 1'b1; iss(4);
    cyc();
    push("flush_vec", 2, 0, 64'h0);
    iss(0);
    cyc();
    push("iss0_vec", 2, 0, 64'h0);
    cyc();

    // Write x10 while it is busy and being read.
    set_wr(0, 10, 32'h5555); cyc();
    iss(10); cyc();
    set_wr(1, 10, 32'hCAFE); set_rd(0, 10); set_rd(1, 10);
    push("byp_vec", 2, 0, 64'h400);
`ifdef REGFILE_BYPASS_EN
    exp_rd("byp_p0", 0, 32'hCAFE, 1'b0);
    exp_rd("byp_p1", 1, 32'hCAFE, 1'b0);
`else
    exp_rd("byp_p0", 0, 32'h5555, 1'b1);
    exp_rd("byp_p1", 1, 32'h5555, 1'b1);
`endif
    cyc();
    set_rd(0, 10);
    exp_rd("x10_after", 0, 32'hCAFE, 1'b0);
    push("x10_vec", 2, 0, 64'h0);
    cyc();

    // Reset in mid-operation drops the in-flight write and clears state.
    iss(11); cyc();
    set_wr(0, 7, 32'h77); set_wr(1, 12, 32'h99);
    rst_n = 1'b0;
    @(posedge clk);
    #1 idle();
    rst_n = 1'b1;
    set_rd(0, 12); set_rd(1, 7);
    exp_rd("rst_mid_x12", 0, 32'h0, 1'b0);
    exp_rd("rst_mid_x7", 1, 32'h0, 1'b0);
    push("rst_mid_vec", 2, 0, 64'h0);
    push("rst_mid_conf", 3, 0, 64'h0);
    cyc();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
